// File: rtl/act_pkg.sv
// Shared constants and address-split helper for the activation bank reader.
// Address layout: bank = low LOG_Z bits of a neuron index, row = remaining high bits.
package act_pkg;

  localparam int p     = 32;
  localparam int z     = 8;
  localparam int fo    = 2;
  localparam int width = 8;

  localparam int LOG_P = $clog2(p);
  localparam int LOG_Z = $clog2(z);
  localparam int ROWS  = p / z;
  localparam int ROW_W = LOG_P - LOG_Z;
  localparam int BEATS = fo * p / z;
  localparam int CNT_W = $clog2(BEATS);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [LOG_Z-1:0] bank;
  } act_loc_t;

  function automatic act_loc_t act_loc(input logic [LOG_P-1:0] idx);
    act_loc_t loc;
    loc.row  = idx[LOG_P-1:LOG_Z];
    loc.bank = idx[LOG_Z-1:0];
    return loc;
  endfunction

endpackage

// File: rtl/act_bank.sv
// One activation bank: ROWS x width storage, one write port and one
// read-first registered read port gated by rd_en.
module act_bank
  import act_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [ROW_W-1:0] rd_row,
  output logic [width-1:0] rd_data
);

  logic [width-1:0] mem [ROWS];

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row] <= wr_data;
  end

  // NOTE: non-blocking read of mem samples the pre-write value, giving read-first on a same-row collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_row];
    end
  end

endmodule

// File: rtl/act_bank_reader.sv
// Reads z interleaved activations per address package into a single output
// stage, counts beats per junction and flags lane/bank mismatches.
module act_bank_reader
  import act_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [LOG_P-1:0]     wr_addr,
  input  logic [width-1:0]     wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [LOG_P*z-1:0]   memory_index_package,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width*z-1:0]   act_package,
  output logic                 junction_done,
  output logic                 addr_err
);

  act_loc_t         wr_loc;
  logic             accept;
  logic             deliver;
  logic [z-1:0]     lane_bad;
  logic [CNT_W-1:0] beat_cnt;

  assign wr_loc   = act_loc(wr_addr);
  assign rd_ready = !out_valid || out_ready;
  assign accept   = rd_valid && rd_ready;
  assign deliver  = out_valid && out_ready;

  for (genvar gi = 0; gi < z; gi++) begin : g_lane
    act_loc_t lane_loc;
    assign lane_loc     = act_loc(memory_index_package[LOG_P*gi +: LOG_P]);
    // Lane gi always reads bank gi; the low address bits only feed the error check.
    assign lane_bad[gi] = (lane_loc.bank != LOG_Z'(gi));

    act_bank u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en && (wr_loc.bank == LOG_Z'(gi))),
      .wr_row  (wr_loc.row),
      .wr_data (wr_data),
      .rd_en   (accept),
      .rd_row  (lane_loc.row),
      .rd_data (act_package[width*gi +: width])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      addr_err      <= 1'b0;
      beat_cnt      <= '0;
      junction_done <= 1'b0;
    end else begin
      if (accept)       out_valid <= 1'b1;
      else if (deliver) out_valid <= 1'b0;

      if (accept && |lane_bad) addr_err <= 1'b1;

      junction_done <= deliver && (beat_cnt == CNT_W'(BEATS - 1));
      if (deliver) begin
        if (beat_cnt == CNT_W'(BEATS - 1)) beat_cnt <= '0;
        else                               beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_act_bank_reader.sv
// Directed bench for act_bank_reader: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares delivered beats.
module tb_act_bank_reader;
  import act_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 wr_en;
  logic [LOG_P-1:0]     wr_addr;
  logic [width-1:0]     wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [LOG_P*z-1:0]   memory_index_package;
  logic                 out_valid;
  logic                 out_ready;
  logic [width*z-1:0]   act_package;
  logic                 junction_done;
  logic                 addr_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [width*z-1:0] sb[$];
  int   beat_m    = 0;
  logic jd_exp    = 1'b0;
  int   jd_pulses = 0;

  always #5 clk = ~clk;

  act_bank_reader dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .rd_valid             (rd_valid),
    .rd_ready             (rd_ready),
    .memory_index_package (memory_index_package),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .act_package          (act_package),
    .junction_done        (junction_done),
    .addr_err             (addr_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LOG_P*z-1:0] id_pkg(input int k);
    logic [LOG_P*z-1:0] r;
    for (int i = 0; i < z; i++) r[LOG_P*i +: LOG_P] = LOG_P'(z*k + i);
    return r;
  endfunction

  function automatic logic [width*z-1:0] id_exp(input int k);
    logic [width*z-1:0] r;
    for (int i = 0; i < z; i++) r[width*i +: width] = width'(z*k + i);
    return r;
  endfunction

  // Present one package, wait (bounded) for acceptance, push the expected beat.
  task automatic send(input logic [LOG_P*z-1:0] pkg, input logic [width*z-1:0] exp,
                      output int tries);
    bit done = 0;
    tries = 0;
    memory_index_package = pkg;
    rd_valid = 1'b1;
    while (!done && tries < 16) begin
      tries++;
      @(negedge clk);
      if (rd_ready) begin
        @(posedge clk);
        sb.push_back(exp);
        done = 1;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    rd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor and junction_done reference model.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      beat_m = 0;
      jd_exp = 1'b0;
    end else begin
      check("junction_done", 64'(junction_done), 64'(jd_exp));
      if (junction_done) jd_pulses++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else check("act_package", act_package, sb.pop_front());
        jd_exp = (beat_m == BEATS - 1);
        beat_m = (beat_m + 1) % BEATS;
      end else begin
        jd_exp = 1'b0;
      end
    end
  end

  initial begin
    int t;
    logic [width*z-1:0] held;
    logic [width*z-1:0] e;
    logic [LOG_P*z-1:0] pk;

    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; memory_index_package = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_act_package", act_package, 64'd0);
    check("reset_addr_err", 64'(addr_err), 64'd0);
    check("reset_rd_ready", 64'(rd_ready), 64'd1);
    @(posedge clk); #1;

    // Fill: activation value = neuron index.
    for (int n = 0; n < p; n++) begin
      wr_en = 1'b1; wr_addr = LOG_P'(n); wr_data = width'(n);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;

    // Identity reads, back-to-back.
    for (int k = 0; k < ROWS; k++) begin
      send(id_pkg(k), id_exp(k), t);
      check("no_bubble_accept", 64'(t), 64'd1);
    end
    idle(2);

    // Backpressure: first beat held for 3 cycles, second package waits.
    out_ready = 1'b0;
    send(id_pkg(0), id_exp(0), t);
    held = id_exp(0);
    memory_index_package = id_pkg(1);
    rd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_rd_ready", 64'(rd_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_act_stable", act_package, held);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(id_pkg(1), id_exp(1), t);
    check("bp_resume_accept", 64'(t), 64'd1);
    idle(2);

    // Stream beats across a junction boundary (6 beats so far).
    for (int b = 0; b < BEATS; b++) send(id_pkg(b % ROWS), id_exp(b % ROWS), t);
    idle(2);
    check("jd_pulses", 64'(jd_pulses), 64'd1);

    // Collision: write 0xAA to neuron 13 while reading it.
    wr_en = 1'b1; wr_addr = LOG_P'(13); wr_data = 8'hAA;
    send(id_pkg(1), id_exp(1), t);
    wr_en = 1'b0;
    e = id_exp(1);
    e[width*5 +: width] = 8'hAA;
    send(id_pkg(1), e, t);
    idle(2);

    // Address error: lane 2 carries neuron 5 (bank bits 5 != 2), reads bank 2 row 0.
    check("addr_err_clean", 64'(addr_err), 64'd0);
    pk = id_pkg(0);
    pk[LOG_P*2 +: LOG_P] = LOG_P'(5);
    send(pk, id_exp(0), t);
    rd_valid = 1'b0;
    @(negedge clk);
    check("addr_err_set", 64'(addr_err), 64'd1);
    @(posedge clk); #1;
    send(id_pkg(2), id_exp(2), t);
    send(id_pkg(3), id_exp(3), t);
    idle(2);
    check("addr_err_sticky", 64'(addr_err), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset with a beat in flight.
    out_ready = 1'b0;
    send(id_pkg(2), id_exp(2), t);
    rd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_act_package", act_package, 64'd0);
    check("midreset_addr_err", 64'(addr_err), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(id_pkg(3), id_exp(3), t);
    idle(3);
    check("post_reset_sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/act_bank_reader.md
Name: act_bank_reader

Overview:
- Downstream consumer of the interleaver's memory_index_package.
- Holds the left-hand layer's p activations in z single-port-per-direction banks, bank = addr % z, row = addr / z.
- Each cycle it reads the z interleaved activations named by one address package and presents them, registered, to the junction datapath.
- It also counts beats per junction and flags address packages that would cause a bank conflict.

Parameters:
- p, 32, number of left-hand neurons (power of 2, p >= 2*z)
- z, 8, parallel lanes / banks (power of 2)
- fo, 2, fan-out; beats per junction = fo*p/z
- width, 8, activation bit width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one activation this cycle
- wr_addr  in  $clog2(p)  neuron index to write
- wr_data  in  width  activation value
- rd_valid  in  1  memory_index_package is valid
- rd_ready  out  1  block can accept a package this cycle
- memory_index_package  in  $clog2(p)*z  lane i address at bits [$clog2(p)*(i+1)-1 : $clog2(p)*i]
- out_valid  out  1  act_package holds a valid beat
- out_ready  in  1  consumer accepts the beat
- act_package  out  width*z  lane i activation at bits [width*(i+1)-1 : width*i]
- junction_done  out  1  one-cycle pulse when the last beat of a junction is delivered
- addr_err  out  1  sticky lane/bank mismatch flag

Behaviour:
- Reset (reset_n low, async): out_valid=0, act_package=0, junction_done=0, addr_err=0, beat counter=0. Bank contents are not reset. rd_ready=1 from the first cycle after release.
- Reset asserted mid-operation discards any in-flight beat immediately.
- Write path:
  - wr_en=1 writes wr_data into bank wr_addr[$clog2(z)-1:0], row wr_addr[$clog2(p)-1:$clog2(z)], on the clock edge.
  - Writes are independent of the read handshake and allowed every cycle.
- Read path, lane i:
  - Reads bank i at row = lane_addr[$clog2(p)-1:$clog2(z)].
  - lane_addr[$clog2(z)-1:0] is not used for bank select.
- Handshake:
  - accept = rd_valid && rd_ready.
  - rd_ready = !out_valid || out_ready (single registered stage, full throughput).
  - Accepted in cycle N gives out_valid=1 with data in cycle N+1 (latency 1).
  - While out_valid && !out_ready, act_package and out_valid hold and no bank read occurs.
  - out_valid clears on out_ready unless a new accept happens the same cycle.
- Read/write collision: a write and an accepted read to the same bank/row in the same cycle is read-first. The read returns the old value; the new value is visible from the next accept.
- Address check: on accept, if any lane i has lane_addr[$clog2(z)-1:0] != i, addr_err sets and holds until reset. The beat is still delivered.
- Beat counter:
  - Width $clog2(fo*p/z); increments on each delivered beat (out_valid && out_ready).
  - Wraps from fo*p/z-1 to 0.
  - The wrap event drives junction_done=1 on the next cycle, for exactly one cycle.
- Widths: all row/bank fields are truncating slices; no arithmetic beyond the counter. fo=1 is legal (p/z beats per junction).

Decomposition:
- Shared package act_pkg holds:
  - localparams LOG_P, LOG_Z, ROWS=p/z, BEATS=fo*p/z
  - a function computing bank and row from a neuron index
- One sub-module, act_bank: ROWS x width storage with one write and one read port, read-first, registered read data with a read enable.
- Instantiated z times in a generate loop; top level holds the handshake, error check and beat counter.

Test Plan:
- Reset/idle: hold reset_n=0, then release with no stimulus -> out_valid=0, act_package=0, addr_err=0, rd_ready=1.
- Fill and identity read:
  - Write activation value = neuron index for 0..31.
  - Issue package with lane i addr = 8*k+i, k=0..3, rd_valid held 1, out_ready=1.
  - Expect lane i = 8*k+i one cycle after each accept, back-to-back with no bubbles.
- Backpressure:
  - out_ready=0 for 3 cycles after first beat -> act_package stable, rd_ready=0, no second accept.
  - Then out_ready=1 -> next beat the following cycle.
- Junction done: stream 8 beats (fo*p/z=8) -> junction_done pulses exactly once, in the cycle after beat 8 is taken. A 9th beat starts the count at 1.
- Collision:
  - Write 0xAA to neuron 13 in the same cycle a package reads neuron 13 (old 13) -> beat returns 13.
  - Next read of 13 returns 0xAA.
- Address error:
  - Package with lane 2 addr = 5 (low bits 5 != 2) -> addr_err=1 next cycle, beat still delivered.
  - addr_err stays 1 across later clean packages until reset_n=0.
